sram_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the 10-entry × 4-bit single-port SRAM. It serialises read and write requests from requesters A and B onto the SRAM's single `we`/`address`/`write_in` port. It captures the SRAM's registered `data_out` and returns it to the winning requester with a valid strobe. Addresses outside the populated range are rejected without touching the memory.

---
 rtl/sram_arbiter.sv | 105 ++++++++++
 tb/tb_sram_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer putting two requesters onto one single-port SRAM.
// Latency: gnt 1 cycle after winning in IDLE, rvalid 2 cycles; requester holds req until gnt.
module sram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_err,
    output logic              b_err,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [2:0] {IDLE, WR, RD, RESP, ERR} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              state_q;
    logic                last_q;   // 1 = B was served last
    logic                id_q;     // 1 = B owns the current access
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                win_b;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                addr_bad;

    assign win_b     = b_req & (~a_req | ~last_q);
    assign sel_we    = win_b ? b_we    : a_we;
    assign sel_addr  = win_b ? b_addr  : a_addr;
    assign sel_wdata = win_b ? b_wdata : a_wdata;
    assign addr_bad  = {1'b0, sel_addr} >= DEPTH_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (a_req || b_req) begin
                        id_q    <= win_b;
                        last_q  <= win_b;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        if (addr_bad)
                            state_q <= ERR;
                        else if (sel_we)
                            state_q <= WR;
                        else
                            state_q <= RD;
                    end
                end
                WR:   state_q <= IDLE;
                RD:   state_q <= RESP;
                RESP: begin
                    rdata_q <= mem_data_out;
                    state_q <= IDLE;
                end
                ERR:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; reset masks them so an interrupted WR never commits.
    logic in_gnt;
    assign in_gnt = (state_q == WR) || (state_q == RD) || (state_q == ERR);

    assign a_gnt        = ~rst & in_gnt & ~id_q;
    assign b_gnt        = ~rst & in_gnt &  id_q;
    assign a_err        = ~rst & (state_q == ERR) & ~id_q;
    assign b_err        = ~rst & (state_q == ERR) &  id_q;
    assign a_rvalid     = ~rst & (state_q == RESP) & ~id_q;
    assign b_rvalid     = ~rst & (state_q == RESP) &  id_q;
    assign mem_we       = ~rst & (state_q == WR);
    assign mem_address  = (~rst && (state_q == WR || state_q == RD)) ? addr_q : '0;
    assign mem_write_in = (~rst && state_q == WR) ? wdata_q : '0;
    assign rdata        = rst ? '0 : ((state_q == RESP) ? mem_data_out : rdata_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Cycle-table bench for sram_arbiter with a behavioural 10x4 SRAM.
module tb_sram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, b_gnt, a_err, b_err, a_rvalid, b_rvalid;
    logic [3:0] rdata;
    logic       mem_we;
    logic [3:0] mem_address, mem_write_in, mem_data_out;

    logic [3:0] sram [16];
    logic       bad_wr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            sram[mem_address] <= mem_write_in;
            if (mem_address >= 4'd10) bad_wr <= 1'b1;
        end
        mem_data_out <= sram[mem_address];
    end

    sram_arbiter #(.ADDR_W(4), .DATA_W(4), .DEPTH(10)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_err(a_err), .b_err(b_err),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid), .rdata(rdata),
        .mem_we(mem_we), .mem_address(mem_address), .mem_write_in(mem_write_in),
        .mem_data_out(mem_data_out)
    );

    // Flag vector order: {a_gnt, a_err, a_rvalid, b_gnt, b_err, b_rvalid, mem_we}
    localparam int AG = 64, AE = 32, AR = 16, BG = 8, BE = 4, BR = 2, WE = 1;

    typedef struct {
        logic       rst;
        logic       ar, aw;
        logic [3:0] aa, ad;
        logic       br, bw;
        logic [3:0] ba, bd;
        logic [6:0] ef;
        logic [3:0] ema;
        logic       crd;
        logic [3:0] erd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int r, input int ar, input int aw, input int aa, input int ad,
                       input int br, input int bw, input int ba, input int bd,
                       input int ef, input int ema, input int crd, input int erd);
        vec_t v;
        v.rst = 1'(r);
        v.ar = 1'(ar); v.aw = 1'(aw); v.aa = 4'(aa); v.ad = 4'(ad);
        v.br = 1'(br); v.bw = 1'(bw); v.ba = 4'(ba); v.bd = 4'(bd);
        v.ef = 7'(ef); v.ema = 4'(ema); v.crd = 1'(crd); v.erd = 4'(erd);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [6:0] got;
        int lat;
        bit seen;

        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

        // reset and idle
        add(1, 0,0,0,0,    0,0,0,0,    0,     0, 1,0);
        add(0, 0,0,0,0,    0,0,0,0,    0,     0, 1,0);
        // A writes 5 to 3, then reads it back
        add(0, 1,1,3,5,    0,0,0,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AG|WE, 3, 0,0);
        add(0, 1,0,3,0,    0,0,0,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AG,    3, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AR,    0, 1,5);
        add(0, 0,0,0,0,    0,0,0,0,    0,     0, 0,0);
        // reset, then both hold writes: grants alternate A, B, A, B
        add(1, 0,0,0,0,    0,0,0,0,    0,     0, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   0,     0, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   AG|WE, 1, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   0,     0, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   BG|WE, 2, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   0,     0, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   AG|WE, 1, 0,0);
        add(0, 1,1,1,10,   1,1,2,11,   0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BG|WE, 2, 0,0);
        add(0, 1,0,1,0,    0,0,0,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AG,    1, 0,0);
        add(0, 0,0,0,0,    1,0,2,0,    AR,    0, 1,10);
        add(0, 0,0,0,0,    1,0,2,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BG,    2, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BR,    0, 1,11);
        // B: top valid address, then out-of-range write
        add(0, 0,0,0,0,    1,1,9,15,   0,     0, 0,0);
        add(0, 0,0,0,0,    1,0,9,0,    BG|WE, 9, 0,0);
        add(0, 0,0,0,0,    1,0,9,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BG,    9, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BR,    0, 1,15);
        add(0, 0,0,0,0,    1,1,10,7,   0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BG|BE, 0, 0,0);
        add(0, 0,0,0,0,    1,0,9,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BG,    9, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BR,    0, 1,15);
        // contention: A write vs B read of addr 4
        add(0, 1,1,4,3,    1,0,4,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    1,0,4,0,    AG|WE, 4, 0,0);
        add(0, 0,0,0,0,    1,0,4,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BG,    4, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    BR,    0, 1,3);
        // reset during WR must not commit
        add(0, 1,1,0,1,    0,0,0,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AG|WE, 0, 0,0);
        add(0, 1,1,0,6,    0,0,0,0,    0,     0, 0,0);
        add(1, 0,0,0,0,    0,0,0,0,    0,     0, 1,0);
        add(0, 1,0,0,0,    0,0,0,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AG,    0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AR,    0, 1,1);
        // address changed after latching is ignored
        add(0, 1,0,3,0,    0,0,0,0,    0,     0, 0,0);
        add(0, 1,0,1,0,    0,0,0,0,    AG,    3, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AR,    0, 1,5);
        // A out-of-range at 15
        add(0, 1,1,15,9,   0,0,0,0,    0,     0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    AG|AE, 0, 0,0);
        add(0, 0,0,0,0,    0,0,0,0,    0,     0, 0,0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst = vecs[i].rst;
            a_req = vecs[i].ar; a_we = vecs[i].aw; a_addr = vecs[i].aa; a_wdata = vecs[i].ad;
            b_req = vecs[i].br; b_we = vecs[i].bw; b_addr = vecs[i].ba; b_wdata = vecs[i].bd;
            @(negedge clk);
            got = {a_gnt, a_err, a_rvalid, b_gnt, b_err, b_rvalid, mem_we};
            chk($sformatf("row%0d_flags", i), int'(got), int'(vecs[i].ef));
            chk($sformatf("row%0d_maddr", i), int'(mem_address), int'(vecs[i].ema));
            if (vecs[i].crd)
                chk($sformatf("row%0d_rdata", i), int'(rdata), int'(vecs[i].erd));
        end

        chk("no_oob_write", int'(bad_wr), 0);

        // B reads addr 2 with a bounded wait on gnt and rvalid
        @(posedge clk);
        #1;
        b_req = 1; b_we = 0; b_addr = 2;
        lat = 0; seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b_gnt) seen = 1;
        end
        b_req = 0;
        chk("hs_gnt_seen", int'(seen), 1);
        chk("hs_gnt_latency", lat, 1);
        lat = 0; seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b_rvalid) seen = 1;
        end
        chk("hs_rvalid_seen", int'(seen), 1);
        chk("hs_rvalid_latency", lat, 1);
        chk("hs_rdata", int'(rdata), 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
